// File: rtl/tta_pkg.sv
// Shared types and defaults for the TTA register-unit transport path.
package tta_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ID_W_DEF      = 4;
  localparam int NUM_UNITS_DEF = 8;

  typedef logic [ID_W_DEF-1:0] unit_id_t;

  // state | meaning
  // IDLE    | waiting for a move, mv_ready_o high
  // READ    | source unit selected, it registers its contents
  // CAPTURE | source read data valid, latched into hold_q
  // WRITE   | destination selected with write strobe, data = hold_q
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } move_state_e;

  typedef struct packed {
    logic                  imm;
    unit_id_t              src;
    unit_id_t              dst;
    logic [DATA_W_DEF-1:0] imm_data;
  } move_req_t;

endpackage

// File: rtl/unit_decoder.sv
// Maps a unit id to a one-hot select; flags ids beyond the attached units.
module unit_decoder
  import tta_pkg::*;
#(
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic [ID_W-1:0]      id,
  input  logic                 en,
  output logic [NUM_UNITS-1:0] onehot,
  output logic                 out_of_range
);

  // Range flag is independent of en so the move can be classified at any state.
  assign out_of_range = (32'(id) >= 32'(NUM_UNITS));

  // One-hot decode, gated by en; an out-of-range id matches no slot.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (en && (id == ID_W'(k))) onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Transport sequencer: accepts one move per handshake and drives the
// register-unit sel/wstrb/data strobes, absorbing the one-cycle read latency.
module move_sequencer
  import tta_pkg::*;
#(
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        mv_valid_i,
  output logic                        mv_ready_o,
  input  logic                        mv_imm_i,
  input  logic [ID_W-1:0]             mv_src_i,
  input  logic [ID_W-1:0]             mv_dst_i,
  input  logic [DATA_W-1:0]           mv_imm_data_i,
  output logic [NUM_UNITS-1:0]        unit_sel_o,
  output logic                        unit_wstrb_o,
  output logic [DATA_W-1:0]           unit_data_o,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_data_i,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        busy_o
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_READ    = READ;
  localparam logic [1:0] S_CAPTURE = CAPTURE;
  localparam logic [1:0] S_WRITE   = WRITE;

  logic [1:0]           state_q, state_d;
  logic                 imm_q;
  logic [ID_W-1:0]      src_q, dst_q;
  logic [DATA_W-1:0]    hold_q, src_rdata;
  logic                 done_q, err_q;
  logic [NUM_UNITS-1:0] src_hot, dst_hot;
  logic                 src_oor, dst_oor, bad, accept;

  assign mv_ready_o = (state_q == S_IDLE) && !rst_i;
  assign accept     = mv_valid_i && mv_ready_o;

  // Source id only matters for register-source moves.
  assign bad = dst_oor || (!imm_q && src_oor);

  unit_decoder #(.NUM_UNITS(NUM_UNITS), .ID_W(ID_W)) u_src_dec (
    .id           (src_q),
    .en           (state_q == S_READ),
    .onehot       (src_hot),
    .out_of_range (src_oor)
  );

  unit_decoder #(.NUM_UNITS(NUM_UNITS), .ID_W(ID_W)) u_dst_dec (
    .id           (dst_q),
    .en           (state_q == S_WRITE),
    .onehot       (dst_hot),
    .out_of_range (dst_oor)
  );

  // Next-state sequencing; immediates skip the read phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = mv_imm_i ? S_WRITE : S_READ;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_WRITE;
      S_WRITE:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Read-data mux on the latched source id; no match yields zero.
  always_comb begin
    src_rdata = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (src_q == ID_W'(k)) src_rdata = unit_data_i[k*DATA_W +: DATA_W];
    end
  end

  // State, latched move fields, hold register and completion pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      imm_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_WRITE);
      err_q   <= (state_q == S_WRITE) && bad;
      if (accept) begin
        imm_q <= mv_imm_i;
        src_q <= mv_src_i;
        dst_q <= mv_dst_i;
        if (mv_imm_i) hold_q <= mv_imm_data_i;
      end else if (state_q == S_CAPTURE) begin
        hold_q <= src_rdata;
      end
    end
  end

  // Outputs decode from registered state only; reset forces them quiet.
  always_comb begin
    unit_sel_o   = (rst_i || bad) ? '0 : (src_hot | dst_hot);
    unit_wstrb_o = !rst_i && (state_q == S_WRITE);
    unit_data_o  = rst_i ? '0 : hold_q;
    done_o       = !rst_i && done_q;
    err_o        = !rst_i && err_q;
    busy_o       = !rst_i && (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural register-unit array.
module tb_move_sequencer;

  localparam int NU = 8;
  localparam int DW = 32;
  localparam int IW = 4;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           mv_valid_i = 1'b0;
  logic           mv_ready_o;
  logic           mv_imm_i = 1'b0;
  logic [IW-1:0]  mv_src_i = '0;
  logic [IW-1:0]  mv_dst_i = '0;
  logic [DW-1:0]  mv_imm_data_i = '0;
  logic [NU-1:0]  unit_sel_o;
  logic           unit_wstrb_o;
  logic [DW-1:0]  unit_data_o;
  logic [NU*DW-1:0] unit_data_i;
  logic           done_o, err_o, busy_o;

  int tests = 0;
  int fails = 0;
  int onehot_viol = 0;

  logic [DW-1:0] mem   [NU] = '{default: '0};
  logic [DW-1:0] rdata [NU] = '{default: '0};
  logic [DW-1:0] shadow[NU] = '{default: '0};

  always #5 clk_i = ~clk_i;

  move_sequencer #(.NUM_UNITS(NU), .DATA_W(DW), .ID_W(IW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mv_valid_i    (mv_valid_i),
    .mv_ready_o    (mv_ready_o),
    .mv_imm_i      (mv_imm_i),
    .mv_src_i      (mv_src_i),
    .mv_dst_i      (mv_dst_i),
    .mv_imm_data_i (mv_imm_data_i),
    .unit_sel_o    (unit_sel_o),
    .unit_wstrb_o  (unit_wstrb_o),
    .unit_data_o   (unit_data_o),
    .unit_data_i   (unit_data_i),
    .done_o        (done_o),
    .err_o         (err_o),
    .busy_o        (busy_o)
  );

  // Register units: write on sel&wstrb, registered read one cycle after sel.
  always @(posedge clk_i) begin
    for (int k = 0; k < NU; k++) begin
      if (unit_sel_o[k] && unit_wstrb_o) mem[k] <= unit_data_o;
      if (unit_sel_o[k]) rdata[k] <= mem[k];
    end
  end

  always_comb begin
    unit_data_i = '0;
    for (int k = 0; k < NU; k++) unit_data_i[k*DW +: DW] = rdata[k];
  end

  always @(negedge clk_i) begin
    if ($countones(unit_sel_o) > 1) onehot_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          imm;
    logic [IW-1:0] src;
    logic [IW-1:0] dst;
    logic [DW-1:0] data;
    int            exp_lat;
    logic          exp_err;
    logic [NU-1:0] exp_sel1;
    logic          exp_wstrb1;
    logic [NU-1:0] exp_wsel;
    logic [DW-1:0] exp_wdata;
    logic          chk_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, d1, d2, w1c;
    logic err;
    logic [NU-1:0] sel1, wsel, wsel1, wsel2;
    logic wstrb1, rdy4, saw_done, saw_wstrb;
    logic [DW-1:0] wdata, wdata1, wdata2;

    vecs[0] = '{1'b1, 4'd0,  4'd2, 32'hDEADBEEF, 2, 1'b0, 8'h04, 1'b1, 8'h04, 32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b1, 4'd0,  4'd1, 32'h12345678, 2, 1'b0, 8'h02, 1'b1, 8'h02, 32'h12345678, 1'b1};
    vecs[2] = '{1'b0, 4'd1,  4'd5, 32'h00000000, 4, 1'b0, 8'h02, 1'b0, 8'h20, 32'h12345678, 1'b1};
    vecs[3] = '{1'b1, 4'd0,  4'd3, 32'h0F0F0F0F, 2, 1'b0, 8'h08, 1'b1, 8'h08, 32'h0F0F0F0F, 1'b1};
    vecs[4] = '{1'b0, 4'd3,  4'd3, 32'h00000000, 4, 1'b0, 8'h08, 1'b0, 8'h08, 32'h0F0F0F0F, 1'b1};
    vecs[5] = '{1'b1, 4'd0,  4'd9, 32'h00000055, 2, 1'b1, 8'h00, 1'b1, 8'h00, 32'h00000055, 1'b1};
    vecs[6] = '{1'b0, 4'd12, 4'd0, 32'h00000000, 4, 1'b1, 8'h00, 1'b0, 8'h00, 32'h00000000, 1'b0};
    vecs[7] = '{1'b0, 4'd2,  4'd7, 32'h00000000, 4, 1'b0, 8'h04, 1'b0, 8'h80, 32'hDEADBEEF, 1'b1};
    vecs[8] = '{1'b1, 4'd13, 4'd0, 32'hCAFEF00D, 2, 1'b0, 8'h01, 1'b1, 8'h01, 32'hCAFEF00D, 1'b1};

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_sel", 32'(unit_sel_o), 32'h0);
    chk("rst_wstrb", 32'(unit_wstrb_o), 32'h0);
    chk("rst_ready", 32'(mv_ready_o), 32'h0);
    chk("rst_busy_done_err", {29'h0, busy_o, done_o, err_o}, 32'h0);
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", 32'(mv_ready_o), 32'h1);

    // Table-driven moves
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      mv_imm_i = vecs[i].imm; mv_src_i = vecs[i].src; mv_dst_i = vecs[i].dst;
      mv_imm_data_i = vecs[i].data; mv_valid_i = 1'b1;
      @(posedge clk_i);
      #1 mv_valid_i = 1'b0;
      lat = 0; err = 1'bx; sel1 = '1; wstrb1 = 1'bx;
      wsel = '1; wdata = '1; saw_wstrb = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk_i);
        if (c == 1) begin sel1 = unit_sel_o; wstrb1 = unit_wstrb_o; end
        if (unit_wstrb_o && !saw_wstrb) begin
          saw_wstrb = 1'b1; wsel = unit_sel_o; wdata = unit_data_o;
        end
        if (done_o) begin lat = c; err = err_o; break; end
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_sel_c1", i), 32'(sel1), 32'(vecs[i].exp_sel1));
      chk($sformatf("v%0d_wstrb_c1", i), 32'(wstrb1), 32'(vecs[i].exp_wstrb1));
      chk($sformatf("v%0d_write_sel", i), 32'(wsel), 32'(vecs[i].exp_wsel));
      if (vecs[i].chk_data)
        chk($sformatf("v%0d_write_data", i), wdata, vecs[i].exp_wdata);
      if (!vecs[i].exp_err) shadow[vecs[i].dst] = vecs[i].exp_wdata;
    end

    // Back-to-back: copy 1->3 then imm 0xA5->6 with valid held high
    @(negedge clk_i);
    mv_imm_i = 1'b0; mv_src_i = 4'd1; mv_dst_i = 4'd3; mv_valid_i = 1'b1;
    @(posedge clk_i);
    d1 = 0; d2 = 0; rdy4 = 1'b0; w1c = 0;
    wsel1 = '1; wdata1 = '1; wsel2 = '1; wdata2 = '1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (c == 1) begin mv_imm_i = 1'b1; mv_dst_i = 4'd6; mv_imm_data_i = 32'h000000A5; end
      if (c == 4) rdy4 = mv_ready_o;
      if (unit_wstrb_o && c < 4) begin w1c = c; wsel1 = unit_sel_o; wdata1 = unit_data_o; end
      if (unit_wstrb_o && c > 4) begin wsel2 = unit_sel_o; wdata2 = unit_data_o; end
      if (done_o) begin
        if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
      end
      if (c == 5) mv_valid_i = 1'b0;
      if (d2 != 0) break;
    end
    chk("b2b_first_write_cycle", 32'(w1c), 32'd3);
    chk("b2b_first_write_sel", 32'(wsel1), 32'h08);
    chk("b2b_first_write_data", wdata1, 32'h12345678);
    chk("b2b_ready_in_done", 32'(rdy4), 32'h1);
    chk("b2b_done1_cycle", 32'(d1), 32'd4);
    chk("b2b_done2_cycle", 32'(d2), 32'd6);
    chk("b2b_second_write_sel", 32'(wsel2), 32'h40);
    chk("b2b_second_write_data", wdata2, 32'h000000A5);
    shadow[3] = 32'h12345678;
    shadow[6] = 32'h000000A5;

    // Reset during CAPTURE of copy 2->4
    @(negedge clk_i);
    mv_imm_i = 1'b0; mv_src_i = 4'd2; mv_dst_i = 4'd4; mv_valid_i = 1'b1;
    @(posedge clk_i);
    #1 mv_valid_i = 1'b0;
    @(negedge clk_i);
    chk("abort_read_sel", 32'(unit_sel_o), 32'h04);
    @(negedge clk_i);
    chk("abort_capture_busy", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_outputs", {unit_sel_o, 21'h0, unit_wstrb_o, done_o, err_o}, 32'h0);
    chk("abort_busy_ready", {30'h0, busy_o, mv_ready_o}, 32'h0);
    chk("abort_data", unit_data_o, 32'h0);
    rst_i = 1'b0;
    #1;
    chk("abort_ready_after", 32'(mv_ready_o), 32'h1);
    saw_done = 1'b0; saw_wstrb = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (done_o || err_o) saw_done = 1'b1;
      if (unit_wstrb_o) saw_wstrb = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'h0);
    chk("abort_no_write", 32'(saw_wstrb), 32'h0);

    // Final unit contents and one-hot invariant
    for (int k = 0; k < NU; k++) chk($sformatf("unit%0d_contents", k), mem[k], shadow[k]);
    chk("sel_onehot_violations", 32'(onehot_viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Upstream transport stage for the register-unit array in the TTA datapath. It accepts one move per handshake: either an immediate to a unit, or a unit-to-unit copy. It drives the per-unit sel/wstrb/data strobes that register units consume, and captures their registered read data. Each register unit presents read data one cycle after being selected, and this block's state machine absorbs that latency.

Parameters:
NUM_UNITS, 8, number of attached register units; slot 0..NUM_UNITS-1
DATA_W, 32, move data width
ID_W, 4, unit-id field width; must satisfy 2**ID_W >= NUM_UNITS

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
mv_valid_i  in  1  move request valid
mv_ready_o  out  1  sequencer can accept a move
mv_imm_i  in  1  1 = source is mv_imm_data_i; 0 = source is unit mv_src_i
mv_src_i  in  ID_W  source unit id; ignored when mv_imm_i=1
mv_dst_i  in  ID_W  destination unit id
mv_imm_data_i  in  DATA_W  immediate value
unit_sel_o  out  NUM_UNITS  one-hot unit select
unit_wstrb_o  out  1  write strobe, shared by all units; qualified by unit_sel_o
unit_data_o  out  DATA_W  write data to units
unit_data_i  in  NUM_UNITS*DATA_W  flattened unit read data; unit k occupies bits [k*DATA_W +: DATA_W]
done_o  out  1  one-cycle pulse when a move completes
err_o  out  1  one-cycle pulse, coincident with done_o, when a move had an out-of-range id
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset is synchronous. While rst_i=1:
  - state=IDLE; hold_q=0; all outputs 0, including mv_ready_o.
  - The first cycle after reset deassertion has mv_ready_o=1.
- Reset mid-move aborts the move with no write. No done_o or err_o is produced for the aborted move.
- mv_ready_o = (state==IDLE) && !rst_i. A move is accepted on a clock edge where mv_valid_i && mv_ready_o; inputs are latched at that edge.
- States: IDLE, READ, CAPTURE, WRITE.
- Register-source move, accepted at edge 0:
  - READ (cycle 1): unit_sel_o=onehot(src), unit_wstrb_o=0. The unit registers its contents at edge 1.
  - CAPTURE (cycle 2): unit_sel_o=0. hold_q <= unit_data_i[src] at edge 2.
  - WRITE (cycle 3): unit_sel_o=onehot(dst), unit_wstrb_o=1, unit_data_o=hold_q.
  - Cycle 4: state IDLE, done_o=1.
  - Accept-to-done latency is 4 cycles.
- Immediate move: IDLE -> WRITE directly, with hold_q <= mv_imm_data_i at the accept edge. done_o follows 2 cycles after accept.
- Back-to-back moves: a new move may be accepted in the done_o cycle because the state is already IDLE. Throughput is one move per 4 cycles (register source) or 2 cycles (immediate).
- unit_data_o equals hold_q in all states; it is only meaningful when unit_wstrb_o=1.
- unit_wstrb_o is 1 only in WRITE.
- At most one bit of unit_sel_o is ever set.
- src==dst is legal: the value is read and written back unchanged.
- Out-of-range ids:
  - Any used id >= NUM_UNITS (src when mv_imm_i=0, or dst) marks the move bad at accept.
  - A bad move still walks the normal state sequence, but unit_sel_o stays 0 in every state.
  - done_o and err_o pulse together at completion.
- Outputs unit_sel_o and unit_wstrb_o decode from the state register and latched ids only; there is no combinational path from mv_* inputs.

Decomposition:
- tta_pkg: DATA_W and ID_W defaults, unit_id_t typedef, move_state_e enum (IDLE, READ, CAPTURE, WRITE), and a move_req_t struct (imm, src, dst, imm_data).
- One sub-module: unit_decoder, which maps an id and an enable to a one-hot NUM_UNITS vector plus an out_of_range flag. It is instantiated twice, for src and dst.

Test Plan:
1. Reset, then immediate move (imm=1, dst=2, data=0xDEADBEEF) -> cycle 1: sel=0b0100, wstrb=1, data_o=0xDEADBEEF; cycle 2: done_o=1; unit 2 reads back 0xDEADBEEF.
2. Preload unit 1 = 0x12345678; copy src=1 -> dst=5 -> cycle 1: sel=0b0000_0010, wstrb=0; cycle 3: sel=0b0010_0000, wstrb=1, data_o=0x12345678; cycle 4: done_o=1.
3. Back-to-back with mv_valid_i held high: copy 1->3, then imm 0xA5 -> 6 -> the second accept lands on the first done_o cycle; two done pulses 2 cycles apart; no cycle with two sel bits set.
4. NUM_UNITS=8, dst=9 (or src=12) -> unit_sel_o=0 throughout; done_o=err_o=1 at completion; all units unchanged.
5. Assert rst_i during CAPTURE of a copy 2->4 -> next cycle all outputs 0; unit 4 not written; no done_o; mv_ready_o=1 the cycle after rst_i falls.
6. Copy src=3 -> dst=3 with unit 3 = 0x0F0F0F0F -> write data equals 0x0F0F0F0F; done_o after 4 cycles; err_o=0.
